sm_result_display: RTL and testbench

Registered display stage directly downstream of the 3-bit sign-magnitude adder. Captures each result (`o`) and its overflow flag on a valid strobe. Keeps a decimal overflow counter and time-multiplexes the four digits of an active-low common-anode 7-segment display, with one blanking cycle per digit to suppress ghosting. All outputs are registered.

---
 rtl/sm_result_display.sv | 98 +++++++++
 tb/tb_sm_result_display.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sm_result_display.sv
// Registered display stage for the 3-bit sign-magnitude adder: captures result/overflow,
// keeps a BCD overflow count and scans four active-low common-anode 7-segment digits.
module sm_result_display #(
  parameter int REFRESH_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] o,
  input  logic       flag,
  input  logic       valid,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(REFRESH_DIV - 1);

  // Digit index doubles as the scan state.
  localparam logic [1:0] DIG0 = 2'd0;
  localparam logic [1:0] DIG1 = 2'd1;
  localparam logic [1:0] DIG2 = 2'd2;
  localparam logic [1:0] DIG3 = 2'd3;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [2:0]       res_q;
  logic             ovf_q;
  logic [3:0]       cnt_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       idx_q;
  logic [6:0]       digit_seg;

  function automatic logic [6:0] bcd_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_seg = 7'b1000000;
      4'd1:    bcd_seg = 7'b1111001;
      4'd2:    bcd_seg = 7'b0100100;
      4'd3:    bcd_seg = 7'b0110000;
      4'd4:    bcd_seg = 7'b0011001;
      4'd5:    bcd_seg = 7'b0010010;
      4'd6:    bcd_seg = 7'b0000010;
      4'd7:    bcd_seg = 7'b1111000;
      4'd8:    bcd_seg = 7'b0000000;
      4'd9:    bcd_seg = 7'b0010000;
      default: bcd_seg = SEG_BLANK;
    endcase
  endfunction

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    digit_seg = SEG_BLANK;
    case (idx_q)
      DIG0: digit_seg = bcd_seg({2'b00, res_q[1:0]});
      // Negative zero is shown without a sign.
      DIG1: digit_seg = (res_q[2] && (res_q[1:0] != 2'b00)) ? SEG_DASH : SEG_BLANK;
      DIG2: digit_seg = ovf_q ? SEG_E : SEG_BLANK;
      DIG3: digit_seg = bcd_seg(cnt_q);
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= 3'b000;
      ovf_q <= 1'b0;
      cnt_q <= 4'd0;
      div_q <= '0;
      idx_q <= DIG0;
      an    <= 4'b1111;
      seg   <= SEG_BLANK;
    end else begin
      if (valid) begin
        res_q <= o;
        ovf_q <= flag;
        if (flag) cnt_q <= (cnt_q == 4'd9) ? 4'd0 : cnt_q + 4'd1;
      end

      if (div_q == DIV_MAX) begin
        div_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end

      // Slot position 0 is the anti-ghosting blank; it precedes every digit change.
      if (div_q == '0) begin
        an  <= 4'b1111;
        seg <= SEG_BLANK;
      end else begin
        an  <= ~(4'b0001 << idx_q);
        seg <= digit_seg;
      end
    end
  end

endmodule

// File: tb/tb_sm_result_display.sv
// Directed bench for sm_result_display: scan order, digit contents, capture latency,
// overflow counter wrap and mid-slot reset, with hand-computed segment codes.
module tb_sm_result_display;

  localparam int REFRESH_DIV = 4;

  logic       clk;
  logic       rst;
  logic [2:0] o;
  logic       flag;
  logic       valid;
  logic [3:0] an;
  logic [6:0] seg;

  int n_checks = 0;
  int n_fail   = 0;

  sm_result_display #(.REFRESH_DIV(REFRESH_DIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .o     (o),
    .flag  (flag),
    .valid (valid),
    .an    (an),
    .seg   (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Step until digit d is lit (bounded), confirm the enable, then check its segments.
  task automatic show(input int d, input logic [6:0] exp_seg, input string tag);
    logic [3:0] want;
    int n;
    want = ~(4'b0001 << d);
    n = 0;
    do begin
      step();
      n++;
    end while (an !== want && n < 64);
    check({tag, "_an"}, 32'(an), 32'(want));
    check({tag, "_seg"}, 32'(seg), 32'(exp_seg));
  endtask

  // Drive one sample for `cycles` consecutive edges, starting from a falling edge.
  task automatic sample(input logic [2:0] v, input logic f, input int cycles);
    o = v;
    flag = f;
    valid = 1'b1;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    flag = 1'b0;
  endtask

  initial begin
    logic [3:0] an_seq [8];
    an_seq = '{4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101, 4'b1101, 4'b1101};

    rst = 1'b1; o = 3'b000; flag = 1'b0; valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_an", 32'(an), 32'h0f);
    check("reset_seg", 32'(seg), 32'h7f);
    rst = 1'b0;

    // Scan order right after reset: E1 blank, E2-E4 digit 0, E5 blank, E6-E8 digit 1.
    for (int e = 0; e < 8; e++) begin
      step();
      check($sformatf("scan_E%0d", e + 1), 32'(an), 32'(an_seq[e]));
      if (e == 1) check("scan_d0_seg", 32'(seg), 32'h40);
      if (e == 4) check("scan_blank_seg", 32'(seg), 32'h7f);
      if (e == 5) check("scan_d1_seg", 32'(seg), 32'h7f);
    end
    show(2, 7'h7f, "rst_d2");
    show(3, 7'h40, "rst_d3");

    // Positive 3.
    sample(3'b011, 1'b0, 1);
    show(0, 7'h30, "p3_d0");
    show(1, 7'h7f, "p3_d1");
    show(2, 7'h7f, "p3_d2");
    show(3, 7'h40, "p3_d3");

    // Capture latency: the capture edge still shows the old digit, the next lit edge the new one.
    show(0, 7'h30, "lat_pre");
    o = 3'b010; valid = 1'b1;
    step();
    valid = 1'b0;
    check("lat_capture_edge_seg", 32'(seg), 32'h30);
    step();
    check("lat_next_edge_an", 32'(an), 32'h0e);
    check("lat_next_edge_seg", 32'(seg), 32'h24);

    // Negative 2.
    sample(3'b110, 1'b0, 1);
    show(0, 7'h24, "n2_d0");
    show(1, 7'h3f, "n2_d1");

    // Negative zero shows plain 0.
    sample(3'b100, 1'b0, 1);
    show(0, 7'h40, "nz_d0");
    show(1, 7'h7f, "nz_d1");

    // First overflow.
    sample(3'b001, 1'b1, 1);
    show(0, 7'h79, "ovf1_d0");
    show(2, 7'h06, "ovf1_d2");
    show(3, 7'h79, "ovf1_d3");

    // Nine more overflows: count 10 wraps to 0.
    for (int i = 0; i < 9; i++) begin
      sample(3'b001, 1'b1, 1);
      step();
    end
    show(2, 7'h06, "wrap_d2");
    show(3, 7'h40, "wrap_d3");

    // valid held three cycles with flag: count 3.
    sample(3'b111, 1'b1, 3);
    show(1, 7'h3f, "hold_d1");
    show(3, 7'h30, "hold_d3");

    // Clean sample clears E but keeps the count.
    sample(3'b011, 1'b0, 1);
    show(2, 7'h7f, "clr_d2");
    show(3, 7'h30, "clr_d3");

    // Reset in the middle of the digit-2 slot.
    show(2, 7'h7f, "mid_pre");
    rst = 1'b1;
    step();
    check("mid_rst_an", 32'(an), 32'h0f);
    check("mid_rst_seg", 32'(seg), 32'h7f);
    rst = 1'b0;
    step();
    check("mid_E1_an", 32'(an), 32'h0f);
    step();
    check("mid_E2_an", 32'(an), 32'h0e);
    check("mid_E2_seg", 32'(seg), 32'h40);
    show(1, 7'h7f, "mid_d1");
    show(2, 7'h7f, "mid_d2");
    show(3, 7'h40, "mid_d3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
